// File: rtl/mips_core_mc.sv
// rtl/mips_core_mc.sv - multi-cycle MIPS core with req/ready instruction and data ports
//
// Purpose: FETCH/DECODE/EXEC/MEM/WB/HALT multi-cycle core built from the regfile,
//          control, alu_control and alu units, with handshaked memory ports,
//          big-endian byte lanes, a bus-timeout watchdog and sticky fault/halt.
// Ports:
//   clk, rst_b                      clock (rising edge), async active-low reset
//   inst_addr/inst_req              fetch address (= pc) and fetch request
//   inst/inst_ready                 fetched word and fetch completion
//   mem_addr/mem_req/mem_write_en   word-aligned data address, request, store flag
//   mem_byte_en                     lane enables, lane 0 = bits [31:24]
//   mem_data_in/mem_data_out        store data to memory / load data from memory
//   mem_ready                       data access completion
//   halted/fault/retired            sticky halt, sticky fault, retire pulse

package mips_core_mc_pkg;
    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_XOR     = 4'd4;
    localparam logic [3:0] ALU_NOR     = 4'd5;
    localparam logic [3:0] ALU_SLT     = 4'd6;
    localparam logic [3:0] ALU_SLTU    = 4'd7;
    localparam logic [3:0] ALU_SLL     = 4'd8;
    localparam logic [3:0] ALU_SRL     = 4'd9;
    localparam logic [3:0] ALU_SRA     = 4'd10;
    localparam logic [3:0] ALU_LUI     = 4'd11;
    // Control asks alu_control to decode the R-type funct field.
    localparam logic [3:0] ALUOP_FUNCT = 4'd15;

    localparam logic [5:0] F_JR        = 6'h08;
    localparam logic [5:0] F_SYSCALL   = 6'h0C;
endpackage

// Two asynchronous read ports, one synchronous write port; r0 reads as zero.
module mips_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
endmodule

// Main decoder: opcode/funct to datapath controls.
module mips_control
    import mips_core_mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       imm_zext,
    output logic       is_load,
    output logic       is_store,
    output logic       byte_op,
    output logic       load_unsigned,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_jal,
    output logic       is_jr,
    output logic       is_syscall,
    output logic [3:0] alu_op
);
    always_comb begin
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src       = 1'b0;
        imm_zext      = 1'b0;
        is_load       = 1'b0;
        is_store      = 1'b0;
        byte_op       = 1'b0;
        load_unsigned = 1'b0;
        is_branch     = 1'b0;
        is_jump       = 1'b0;
        is_jal        = 1'b0;
        is_jr         = 1'b0;
        is_syscall    = 1'b0;
        alu_op        = ALU_ADD;
        case (opcode)
            6'h00: begin
                if (funct == F_JR) begin
                    is_jr = 1'b1;
                end else if (funct == F_SYSCALL) begin
                    is_syscall = 1'b1;
                end else begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
            end
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: is_branch = 1'b1;
            6'h02: is_jump = 1'b1;
            6'h03: begin
                is_jump   = 1'b1;
                is_jal    = 1'b1;
                reg_write = 1'b1;
            end
            6'h08, 6'h09: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            6'h0A: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_SLT;  end
            6'h0B: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_SLTU; end
            6'h0C: begin reg_write = 1'b1; alu_src = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
            6'h0D: begin reg_write = 1'b1; alu_src = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR;  end
            6'h0E: begin reg_write = 1'b1; alu_src = 1'b1; imm_zext = 1'b1; alu_op = ALU_XOR; end
            6'h0F: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_LUI; end
            6'h20: begin reg_write = 1'b1; alu_src = 1'b1; is_load = 1'b1; byte_op = 1'b1; end
            6'h23: begin reg_write = 1'b1; alu_src = 1'b1; is_load = 1'b1; end
            6'h24: begin
                reg_write     = 1'b1;
                alu_src       = 1'b1;
                is_load       = 1'b1;
                byte_op       = 1'b1;
                load_unsigned = 1'b1;
            end
            6'h28: begin alu_src = 1'b1; is_store = 1'b1; byte_op = 1'b1; end
            6'h2B: begin alu_src = 1'b1; is_store = 1'b1; end
            default: ;
        endcase
    end
endmodule

module mips_alu_control
    import mips_core_mc_pkg::*;
(
    input  logic [3:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl
);
    always_comb begin
        alu_ctl = alu_op;
        if (alu_op == ALUOP_FUNCT) begin
            case (funct)
                6'h20, 6'h21: alu_ctl = ALU_ADD;
                6'h22, 6'h23: alu_ctl = ALU_SUB;
                6'h24:        alu_ctl = ALU_AND;
                6'h25:        alu_ctl = ALU_OR;
                6'h26:        alu_ctl = ALU_XOR;
                6'h27:        alu_ctl = ALU_NOR;
                6'h2A:        alu_ctl = ALU_SLT;
                6'h2B:        alu_ctl = ALU_SLTU;
                6'h00:        alu_ctl = ALU_SLL;
                6'h02:        alu_ctl = ALU_SRL;
                6'h03:        alu_ctl = ALU_SRA;
                default:      alu_ctl = ALU_ADD;
            endcase
        end
    end
endmodule

module mips_alu
    import mips_core_mc_pkg::*;
(
    input  logic [3:0]  alu_ctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result
);
    always_comb begin
        case (alu_ctl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
            ALU_LUI:  result = {b[15:0], 16'd0};
            default:  result = a + b;
        endcase
    end
endmodule

module mips_core_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 0,
    parameter int          TCW      = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    output logic [31:0]      inst_addr,
    output logic             inst_req,
    input  logic [31:0]      inst,
    input  logic             inst_ready,
    output logic [31:0]      mem_addr,
    output logic             mem_req,
    output logic             mem_write_en,
    output logic [0:3]       mem_byte_en,
    output logic [0:3][7:0]  mem_data_in,
    input  logic [0:3][7:0]  mem_data_out,
    input  logic             mem_ready,
    output logic             halted,
    output logic             fault,
    output logic             retired
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    // Last wait cycle allowed; hitting it with ready still low trips the watchdog.
    localparam logic [TCW-1:0] TLIM = (TIMEOUT == 0) ? '0 : TCW'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [31:0] pc, ir, a_q, b_q, alu_q, npc_q, mdr;
    logic [TCW-1:0] tcnt;
    logic        started;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];

    logic reg_write, reg_dst, alu_src, imm_zext, is_load, is_store, byte_op;
    logic load_unsigned, is_branch, is_jump, is_jal, is_jr, is_syscall;
    logic [3:0] alu_op, alu_ctl;

    mips_control u_control (
        .opcode        (opcode),
        .funct         (funct),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .alu_src       (alu_src),
        .imm_zext      (imm_zext),
        .is_load       (is_load),
        .is_store      (is_store),
        .byte_op       (byte_op),
        .load_unsigned (load_unsigned),
        .is_branch     (is_branch),
        .is_jump       (is_jump),
        .is_jal        (is_jal),
        .is_jr         (is_jr),
        .is_syscall    (is_syscall),
        .alu_op        (alu_op)
    );

    mips_alu_control u_alu_control (
        .alu_op  (alu_op),
        .funct   (funct),
        .alu_ctl (alu_ctl)
    );

    logic        rd_we;
    logic [4:0]  wa;
    logic [31:0] wd, rs_val, rt_val;

    assign wa = is_jal ? 5'd31 : (reg_dst ? rd : rt);
    assign wd = is_load ? mdr : (is_jal ? pc + 32'd8 : alu_q);

    mips_regfile u_regfile (
        .clk (clk),
        .we  (rd_we),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (wa),
        .wd  (wd),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    logic [31:0] imm_sext, imm_ext, alu_b, alu_result;
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_ext  = imm_zext ? {16'd0, imm} : imm_sext;
    assign alu_b    = alu_src ? imm_ext : b_q;

    mips_alu u_alu (
        .alu_ctl (alu_ctl),
        .a       (a_q),
        .b       (alu_b),
        .shamt   (shamt),
        .result  (alu_result)
    );

    // Next-pc resolution, evaluated in EXEC from the latched register operands.
    logic [31:0] pc4, br_target, next_pc;
    logic        taken;
    assign pc4       = pc + 32'd4;
    assign br_target = pc4 + {imm_sext[29:0], 2'b00};

    always_comb begin
        case (opcode)
            6'h04:   taken = (a_q == b_q);
            6'h05:   taken = (a_q != b_q);
            6'h06:   taken = a_q[31] || (a_q == 32'd0);
            6'h07:   taken = !a_q[31] && (a_q != 32'd0);
            // REGIMM: rt=1 is bgez, rt=0 is bltz.
            6'h01:   taken = rt[0] ? !a_q[31] : a_q[31];
            default: taken = 1'b0;
        endcase
    end

    assign next_pc = is_jr ? a_q :
                     is_jump ? {pc4[31:28], ir[25:0], 2'b00} :
                     (is_branch && taken) ? br_target : pc4;

    // Data port. Everything below is derived from registers that stay constant
    // during MEM, so the request fields are stable until mem_ready.
    logic        misaligned;
    logic [3:0]  lane_sel;
    logic [7:0]  lane_byte;
    logic [31:0] load_val;

    assign misaligned   = !byte_op && (alu_q[1:0] != 2'b00);
    assign lane_sel     = 4'b1000 >> alu_q[1:0];
    assign mem_req      = (state == S_MEM) && !misaligned;
    assign mem_addr     = {alu_q[31:2], 2'b00};
    assign mem_write_en = mem_req && is_store;
    assign mem_byte_en  = !mem_req ? 4'b0000 : (byte_op ? lane_sel : 4'b1111);
    assign mem_data_in  = byte_op ? {4{b_q[7:0]}} : b_q;
    assign lane_byte    = mem_data_out[alu_q[1:0]];
    assign load_val     = !byte_op ? mem_data_out :
                          load_unsigned ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};

    // The first cycle out of reset never requests, so a stale ready is ignored.
    assign inst_req  = (state == S_FETCH) && started;
    assign inst_addr = pc;
    assign halted    = (state == S_HALT);

    logic wait_now, timeout_hit;
    assign wait_now    = (inst_req && !inst_ready) || (mem_req && !mem_ready);
    assign timeout_hit = (TIMEOUT != 0) && wait_now && (tcnt == TLIM);

    logic        pc_load, fault_set, ir_load;
    logic [31:0] pc_n;
    assign pc_n = (state == S_EXEC) ? next_pc : npc_q;

    always_comb begin
        state_n   = state;
        retired   = 1'b0;
        rd_we     = 1'b0;
        pc_load   = 1'b0;
        fault_set = 1'b0;
        ir_load   = 1'b0;
        case (state)
            S_FETCH: begin
                if (timeout_hit) begin
                    fault_set = 1'b1;
                    state_n   = S_HALT;
                end else if (inst_req && inst_ready) begin
                    ir_load = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_syscall) begin
                    retired = 1'b1;
                    state_n = S_HALT;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_n = S_MEM;
                end else if ((is_branch || is_jump || is_jr) && !is_jal) begin
                    pc_load = 1'b1;
                    retired = 1'b1;
                    state_n = S_FETCH;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                if (misaligned || timeout_hit) begin
                    fault_set = 1'b1;
                    state_n   = S_HALT;
                end else if (mem_ready) begin
                    if (is_store) begin
                        pc_load = 1'b1;
                        retired = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end
            end
            S_WB: begin
                rd_we   = reg_write;
                pc_load = 1'b1;
                retired = 1'b1;
                state_n = S_FETCH;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            npc_q   <= 32'd0;
            mdr     <= 32'd0;
            tcnt    <= '0;
            started <= 1'b0;
            fault   <= 1'b0;
        end else begin
            started <= 1'b1;
            if (pc_load) begin
                pc <= pc_n;
            end
            if (ir_load) begin
                ir <= inst;
            end
            if (state == S_DECODE) begin
                a_q <= rs_val;
                b_q <= rt_val;
            end
            if (state == S_EXEC) begin
                alu_q <= alu_result;
                npc_q <= next_pc;
            end
            if (mem_req && mem_ready && !is_store) begin
                mdr <= load_val;
            end
            if (fault_set) begin
                fault <= 1'b1;
            end
            // Counts consecutive unanswered request cycles within one state.
            if (wait_now && state_n == state) begin
                tcnt <= tcnt + TCW'(1);
            end else begin
                tcnt <= '0;
            end
        end
    end
endmodule

// File: doc/mips_core_mc.md
Name: mips_core_mc

Overview:
- Multi-cycle successor to the single-cycle MIPS core. Reuses the existing regfile, control, alu_control and alu units.
- Replaces the combinational instruction and data ports with req/ready handshakes, so wait-state memories or caches can be attached.
- Completes the load/store datapath: lw, lb, lbu, sw, sb with byte enables.
- Adds a configurable reset vector, a bus-timeout watchdog, a fault flag and a retire pulse for the bench.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded at reset.
- TIMEOUT, 0, number of cycles a req may wait for ready before a fault is raised; 0 disables the watchdog.
- TCW, 8, width of the timeout counter. Requires TIMEOUT < 2**TCW.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- inst_addr  out  32  fetch address, always equal to pc.
- inst_req  out  1  fetch request.
- inst  in  32  instruction word, valid while inst_ready.
- inst_ready  in  1  fetch complete.
- mem_addr  out  32  data address, word-aligned (effective address with bits [1:0] forced to 0).
- mem_req  out  1  data request.
- mem_write_en  out  1  1 = store, 0 = load; meaningful only while mem_req.
- mem_byte_en  out  4  lane enables; lane i = byte address offset i.
- mem_data_in  out  8x[0:3]  store data to memory.
- mem_data_out  in  8x[0:3]  load data from memory, valid while mem_ready.
- mem_ready  in  1  data access complete.
- halted  out  1  sticky; syscall decoded or fault.
- fault  out  1  sticky; misaligned access or bus timeout.
- retired  out  1  one-cycle pulse per completed instruction.

Behaviour:
- Reset (async, rst_b=0): state=FETCH, pc=RESET_PC, IR=0, timeout counter=0. Outputs: halted=0, fault=0, retired=0, mem_req=0, inst_req=0, mem_byte_en=0. A request in flight is abandoned; a ready arriving on the first cycle after rst_b deasserts is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: inst_req=1. When inst_ready is sampled 1, IR<=inst and go to DECODE. Ready in the same cycle as req is legal (zero wait).
- DECODE: register read. Syscall (opcode 0, func 6'b001100): go to HALT, set halted=1, assert retired, pc unchanged. All other instructions go to EXEC.
- EXEC: ALU evaluation and next-pc resolution; next-pc rules are unchanged from the single-cycle core.
  - Branches beq, bne, blez, bgtz, bgez use target pc+4+(sext(imm)<<2). Jumps use {pc4[31:28], addr26, 2'b00}. jr uses rs.
  - Branch, j, jr (no link): pc<=next_pc, assert retired, go to FETCH.
  - jal and ALU ops: go to WB. Loads and stores: go to MEM.
- MEM: address = alu_result.
  - lw/sw with ea[1:0]!=0: fault=1, halted=1, go to HALT. No request is issued and pc is unchanged.
  - Otherwise mem_req=1. mem_addr, mem_write_en, mem_byte_en and mem_data_in are held stable until mem_ready.
  - Byte order is big-endian: lane 0 = bits [31:24].
  - sw: byte_en=4'b1111. sb: one-hot lane ea[1:0], rt[7:0] replicated on all lanes. lw/lb/lbu: byte_en as for the store forms.
  - On mem_ready: load data is latched into MDR and the state goes to WB. A store sets pc<=pc+4, asserts retired and goes to FETCH.
  - lb sign-extends the selected lane; lbu zero-extends it.
- WB: rd_we=1 for exactly this one cycle. Write data is MDR (load), pc+8 into r31 (jal), or alu_result. Writes to r0 are discarded by the regfile. pc<=next_pc, assert retired, go to FETCH.
- Timeout: the counter increments each cycle a req is high and ready is low, and clears when ready is sampled or the request state is exited. If TIMEOUT!=0 and the count reaches TIMEOUT: fault=1, halted=1, the req is dropped next cycle, go to HALT.
- HALT: absorbing. All req=0, no register writes, pc frozen; only reset leaves this state.
- A ready arriving while its req is low is ignored.
- Minimum latency with zero-wait memory (cycles): ALU/jal 4, load 5, store 4, branch/jump 3, syscall 2.
- pc arithmetic wraps modulo 2^32.

Test Plan:
- ALU, zero wait: addi r1,r0,5; addi r2,r1,-7 -> r2=32'hFFFF_FFFE; retired pulses at cycles 4 and 8 after reset.
- Wait states: inst_ready delayed 3 cycles per fetch -> inst_req and inst_addr held stable throughout; r1=5 retired at cycle 7; no duplicate IR capture.
- Byte loads: memory word at 0x100 = 32'h80FF_1234.
  - lb from 0x101 -> 32'hFFFF_FFFF.
  - lbu from 0x100 -> 32'h0000_0080.
  - lw from 0x100 -> 32'h80FF_1234.
  - sb from 0x102 with rt=0xAB -> byte_en=4'b0010 and lane 2 = 0xAB.
- Control flow: beq taken at pc=0x40 with imm=3 -> next fetch 0x50. jal at 0x60 -> r31=0x68, then jr r31 returns to 0x68. bgez with rs=-1 falls through.
- Faults:
  - lw from 0x102 -> fault=1 and halted=1 with no mem_req.
  - TIMEOUT=4 with mem_ready held low -> fault after 4 req cycles and the req drops.
  - syscall -> halted=1, fault=0.
- Reset mid-MEM: assert rst_b=0 while mem_req=1 and mem_ready is pending -> mem_req low immediately; after release, fetch restarts at RESET_PC=0x400 and halted=0.
